pattern_0101_0110_generator: RTL
================================

Name: pattern_0101_0110_generator

Overview:
- Serial pattern transmitter. It is the stimulus-side counterpart of the 0101/0110 sequence detectors.
- It accepts a command over a valid/ready handshake, then emits the selected 4-bit pattern (0101 or 0110) MSB-first on a 1-bit serial line, repeated a programmed number of times.
- An optional idle gap separates repetitions, and a done pulse marks the end of the burst.
- Used to drive detector inputs in-system and in self-test.

Parameters:
- CNT_W, 4, width of the repetition count; max burst = 2^CNT_W-1 repetitions.
- GAP_CYCLES, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back). Range 0..15.
- IDLE_BIT, 1'b1, value driven on out whenever out_valid=0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  command valid
- sel  input  1  pattern select: 0 = 0101, 1 = 0110
- count  input  CNT_W  number of repetitions
- abort  input  1  synchronous burst cancel
- cmd_ready  output  1  high when a command can be accepted
- out  output  1  serial data bit, registered
- out_valid  output  1  high when out carries a pattern bit, registered
- busy  output  1  high from the cycle after acceptance until return to IDLE
- done  output  1  single-cycle pulse marking burst completion

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous, active-high. It forces state=IDLE, out=IDLE_BIT, out_valid=0, busy=0, done=0, and clears all counters immediately, without waiting for a clock edge.
- Registered outputs: all outputs except cmd_ready are registered. cmd_ready = (state==IDLE), combinational from state.
- Handshake:
  - A command is accepted at a posedge where start=1 and cmd_ready=1.
  - sel and count are latched at acceptance. Changes afterwards are ignored until the next acceptance.
  - start while not ready is ignored (no queuing).
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - On accept with count!=0: go to SEND, bit index=3, reps_left=count.
  - On accept with count==0: go to DONE. No bits are emitted.
- SEND:
  - Each cycle, out = pattern[bit_idx] and out_valid=1.
  - pattern = 4'b0101 (sel=0) or 4'b0110 (sel=1), so bit order on the wire is left to right.
  - bit_idx decrements 3,2,1,0.
  - At bit_idx=0:
    - If reps_left==1, go to DONE.
    - Else decrement reps_left, reload bit_idx=3, then go to GAP if GAP_CYCLES>0, else stay in SEND (back-to-back).
- GAP:
  - out_valid=0 and out=IDLE_BIT for exactly GAP_CYCLES cycles, then return to SEND with bit_idx=3.
- DONE:
  - One cycle with done=1, out_valid=0 and busy=0, then IDLE.
- Latency:
  - The first pattern bit is visible on out/out_valid in the cycle following the accepting edge.
  - A burst of N repetitions occupies 4N + (N-1)*GAP_CYCLES output cycles, followed by 1 done cycle.
  - The earliest next accept is the edge after the DONE cycle.
- busy: 1 in SEND and GAP, 0 in IDLE and DONE.
- abort:
  - Sampled in SEND or GAP: next state IDLE, out_valid=0, out=IDLE_BIT, no done pulse. Any partial pattern is truncated.
  - abort in IDLE or DONE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Reset mid-burst: outputs return to reset values asynchronously. After release the block is in IDLE with cmd_ready=1. No done pulse is produced.
- Counters:
  - bit_idx is 2 bits.
  - reps_left is CNT_W bits and never underflows, because the count==0 case is routed straight to DONE.
  - The gap counter is 4 bits and wraps only by reload.

Test Plan:
1. reset=1 then release, start=1 sel=0 count=1 -> first output cycle next edge; out=0,1,0,1 with out_valid=1 for 4 cycles; done=1 on cycle 5; cmd_ready=1 on cycle 6. A 0101 detector driven by out asserts once.
2. sel=1, count=3, GAP_CYCLES=0 -> 12 consecutive valid bits 011001100110; done after bit 12; busy high for exactly 12 cycles.
3. sel=0, count=2, GAP_CYCLES=2 -> 0101, two cycles with out_valid=0 and out=1, 0101, done; total 10 output cycles plus done.
4. count=0 accepted -> out_valid never asserts; done=1 the cycle after accept; back to IDLE the following cycle.
5. abort=1 on the 2nd bit of a sel=1, count=2 burst -> only bits 0,1 emitted; next cycle out_valid=0, out=1, cmd_ready=1; done never pulses. start asserted while busy is ignored (no second burst).
6. Async reset asserted mid-bit, between clock edges -> out_valid=0, busy=0, out=IDLE_BIT before the next edge. After release, a new command (sel=0, count=1) runs cleanly.

Source files
------------

// File: rtl/pattern_0101_0110_generator.sv
// Serial 0101/0110 pattern transmitter.
// Accepts a command on start/cmd_ready, then shifts the chosen 4-bit pattern
// out MSB-first, repeated `count` times. Repetitions can be separated by
// GAP_CYCLES idle cycles, and a one-cycle done pulse ends the burst.
module pattern_0101_0110_generator #(
  parameter int   CNT_W      = 4,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             cmd_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  // The gap counter counts down to zero, so it is loaded with one less than
  // the gap length. It is never loaded when GAP_CYCLES is zero.
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  state_t           state, state_nxt;
  logic [1:0]       bit_idx, idx_nxt;
  logic [CNT_W-1:0] reps_left, reps_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic [3:0]       pat, pat_nxt;
  logic             out_nxt, out_valid_nxt, busy_nxt, done_nxt;

  assign cmd_ready = (state == IDLE);

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= 2'd0;
      reps_left <= '0;
      gap_cnt   <= 4'd0;
      pat       <= 4'd0;
      out       <= IDLE_BIT;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= idx_nxt;
      reps_left <= reps_nxt;
      gap_cnt   <= gap_nxt;
      pat       <= pat_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and counter logic. Outputs are decoded from the next state, so
  // the registered outputs line up with the state they describe.
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    reps_nxt  = reps_left;
    gap_nxt   = gap_cnt;
    pat_nxt   = pat;
    case (state)
      IDLE: begin
        // abort is ignored here, so start always takes priority.
        if (start) begin
          pat_nxt = sel ? 4'b0110 : 4'b0101;
          if (count != '0) begin
            state_nxt = SEND;
            idx_nxt   = 2'd3;
            reps_nxt  = count;
          end else begin
            // An empty burst goes straight to DONE, so reps_left never underflows.
            state_nxt = DONE;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_idx == 2'd0) begin
          if (reps_left == CNT_W'(1)) begin
            state_nxt = DONE;
          end else begin
            reps_nxt = reps_left - CNT_W'(1);
            idx_nxt  = 2'd3;
            if (HAS_GAP) begin
              state_nxt = GAP;
              gap_nxt   = GAP_LOAD;
            end
          end
        end else begin
          idx_nxt = bit_idx - 2'd1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == 4'd0) begin
          state_nxt = SEND;
          idx_nxt   = 2'd3;
        end else begin
          gap_nxt = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    out_valid_nxt = (state_nxt == SEND);
    out_nxt       = (state_nxt == SEND) ? pat_nxt[idx_nxt] : IDLE_BIT;
    busy_nxt      = (state_nxt == SEND) || (state_nxt == GAP);
    done_nxt      = (state_nxt == DONE);
  end

endmodule
